multicycle_alu: RTL and testbench

Parametrised, registered successor to the datapath's combinational ALU. It executes the same 5-bit ALU opcode set on WIDTH-bit operands. Single-cycle ops complete in one clock; signed multiply (radix-2 Booth) and signed divide (non-restoring) iterate one bit per clock. It sits between the Y/bus operand sources and the Z register, and the control unit sequences it with a start/done handshake instead of fixed wait states.

---
 rtl/multicycle_alu.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with a start/done handshake.
// Single-cycle ops finish at the accepting edge. Signed multiply uses radix-2 Booth
// and signed divide uses non-restoring division; both retire one bit per clock.
// Optional feature: define MULTICYCLE_ALU_DIV_EN to build the divider (DIV/DIVFIX).
// Without it, the div opcode is treated as an unlisted opcode and div_zero stays 0.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero,
    output logic               illegal_op
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIVFIX} aluState;
    aluState state, stateNext;

    logic               finish;
    logic               finIllegal;
    logic [2*WIDTH-1:0] finResult;
    logic               loadMul;
    logic               startIter;
    logic [CW-1:0]      iterCount;

    // Booth product register: {acc (WIDTH+1), multiplier (WIDTH), q[-1]}.
    // The extra accumulator bit keeps acc - minValue from overflowing.
    logic signed [WIDTH-1:0]   mcand;
    logic signed [2*WIDTH+1:0] prod;
    logic signed [2*WIDTH+1:0] prodNext;
    logic signed [WIDTH:0]     accSum;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic                    loadDiv;
    logic                    finDivZero;
    logic                    negQuo;
    logic                    negRem;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        dvsr;
    logic [WIDTH-1:0]        aMag;
    logic [WIDTH-1:0]        bMag;
    logic [WIDTH-1:0]        remLow;
    logic [WIDTH-1:0]        remOut;
    logic [WIDTH-1:0]        quoOut;
    // Partial remainder stays in [-d, d); the shifted value needs two guard bits.
    logic signed [WIDTH+1:0] rem;
    logic signed [WIDTH+1:0] remShift;
    logic signed [WIDTH+1:0] remNext;
`endif

    function automatic logic [WIDTH-1:0] singleCycle(input logic [4:0] opc,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0]      dbl;
        logic [WIDTH-1:0]        amt;
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sra;
        dbl = {x, x};
        amt = y % WIDTH_V;
        sx  = x;
        sra = sx >>> y;
        case (opc)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_SHR:  return (y >= WIDTH_V) ? '0 : (x >> y);
            OP_SHRA: return (y >= WIDTH_V) ? {WIDTH{x[WIDTH-1]}} : sra;
            OP_SHL:  return (y >= WIDTH_V) ? '0 : (x << y);
            OP_ROR: begin
                dbl = dbl >> amt;
                return dbl[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl = dbl << amt;
                return dbl[2*WIDTH-1:WIDTH];
            end
            OP_NEG:  return -x;
            OP_NOT:  return ~x;
            default: return '0;
        endcase
    endfunction

    // State register; clear forces IDLE and drops any in-flight mul/div.
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state, operand loading and completion decode.
    always_comb begin
        stateNext  = state;
        finish     = 1'b0;
        finResult  = '0;
        finIllegal = 1'b0;
        loadMul    = 1'b0;
        startIter  = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        loadDiv    = 1'b0;
        finDivZero = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                        OP_ROR, OP_ROL, OP_NEG, OP_NOT: begin
                            finish    = 1'b1;
                            finResult = {{WIDTH{1'b0}}, singleCycle(op, a, b)};
                        end
                        OP_MUL: begin
                            stateNext = MUL;
                            loadMul   = 1'b1;
                            startIter = 1'b1;
                        end
`ifdef MULTICYCLE_ALU_DIV_EN
                        OP_DIV: begin
                            if (b == '0) begin
                                finish     = 1'b1;
                                finResult  = {a, {WIDTH{1'b1}}};
                                finDivZero = 1'b1;
                            end else begin
                                stateNext = DIV;
                                loadDiv   = 1'b1;
                                startIter = 1'b1;
                            end
                        end
`endif
                        default: begin
                            finish     = 1'b1;
                            finIllegal = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                if (iterCount == LAST_ITER) begin
                    finish    = 1'b1;
                    finResult = prodNext[2*WIDTH:1];
                    stateNext = IDLE;
                end
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            DIV: begin
                if (iterCount == LAST_ITER) stateNext = DIVFIX;
            end
            DIVFIX: begin
                finish    = 1'b1;
                finResult = {remOut, quoOut};
                stateNext = IDLE;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    // One Booth step: add/subtract the multiplicand, then arithmetic shift right.
    always_comb begin
        accSum = prod[2*WIDTH+1:WIDTH+1];
        case (prod[1:0])
            2'b01:   accSum = prod[2*WIDTH+1:WIDTH+1] + {mcand[WIDTH-1], mcand};
            2'b10:   accSum = prod[2*WIDTH+1:WIDTH+1] - {mcand[WIDTH-1], mcand};
            default: accSum = prod[2*WIDTH+1:WIDTH+1];
        endcase
        prodNext = $signed({accSum, prod[WIDTH:0]}) >>> 1;
    end

    // Multiplier datapath and shared iteration counter.
    always_ff @(posedge clock) begin
        if (loadMul) begin
            mcand <= a;
            prod  <= {{(WIDTH+1){1'b0}}, b, 1'b0};
        end else if (state == MUL) begin
            prod <= prodNext;
        end
        iterCount <= startIter ? '0 : iterCount + 1'b1;
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    // Magnitudes in, one non-restoring step, final remainder fix and sign application.
    always_comb begin
        aMag     = a[WIDTH-1] ? -a : a;
        bMag     = b[WIDTH-1] ? -b : b;
        remShift = {rem[WIDTH:0], quo[WIDTH-1]};
        remNext  = rem[WIDTH+1] ? remShift + {2'b00, dvsr} : remShift - {2'b00, dvsr};
        remLow   = rem[WIDTH+1] ? rem[WIDTH-1:0] + dvsr : rem[WIDTH-1:0];
        remOut   = negRem ? -remLow : remLow;
        quoOut   = negQuo ? -quo : quo;
    end

    // Divider datapath: load magnitudes and signs, then shift quotient bits in.
    always_ff @(posedge clock) begin
        if (loadDiv) begin
            rem    <= '0;
            quo    <= aMag;
            dvsr   <= bMag;
            negQuo <= a[WIDTH-1] ^ b[WIDTH-1];
            negRem <= a[WIDTH-1];
        end else if (state == DIV) begin
            rem <= remNext;
            quo <= {quo[WIDTH-2:0], ~remNext[WIDTH+1]};
        end
    end

    // Divide-by-zero flag, refreshed at every completion.
    always_ff @(posedge clock) begin
        if (clear)       div_zero <= 1'b0;
        else if (finish) div_zero <= finDivZero;
    end
`else
    assign div_zero = 1'b0;
`endif

    // Handshake and result registers; result and flags change only on completion.
    always_ff @(posedge clock) begin
        if (clear) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            illegal_op <= 1'b0;
        end else begin
            busy <= (stateNext != IDLE);
            done <= finish;
            if (finish) begin
                result     <= finResult;
                illegal_op <= finIllegal;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed and randomized checks of multicycle_alu (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_multicycle_alu;
    localparam int W = 32;

    localparam logic [4:0] ADD = 5'd3,  SUB = 5'd4,  AND_ = 5'd5, OR_ = 5'd6;
    localparam logic [4:0] SHR = 5'd7,  SHRA = 5'd8, SHL = 5'd9,  ROR = 5'd10;
    localparam logic [4:0] ROL = 5'd11, MUL = 5'd15, DIV = 5'd16, NEG = 5'd17;
    localparam logic [4:0] NOT_ = 5'd18;
    localparam logic [4:0] LISTED [13] = '{ADD, SUB, AND_, OR_, SHR, SHRA, SHL,
                                           ROR, ROL, MUL, DIV, NEG, NOT_};

    logic           clock = 1'b0;
    logic           clear;
    logic           start;
    logic [4:0]     opIn;
    logic [W-1:0]   aIn;
    logic [W-1:0]   bIn;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           divZero;
    logic           illegalOp;

    int nCompared   = 0;
    int nMismatched = 0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clock(clock), .clear(clear), .start(start), .op(opIn), .a(aIn), .b(bIn),
        .busy(busy), .done(done), .result(result), .div_zero(divZero),
        .illegal_op(illegalOp)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation rules, using 64-bit arithmetic.
    task automatic refModel(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [2*W-1:0] r, output logic dz, output logic ill,
                            output int lat);
        logic signed [63:0] sx, sy, q, rm;
        int n;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        r   = '0;
        dz  = 1'b0;
        ill = 1'b0;
        lat = 1;
        n   = int'(y % 32);
        case (o)
            ADD:  r[31:0] = x + y;
            SUB:  r[31:0] = x - y;
            AND_: r[31:0] = x & y;
            OR_:  r[31:0] = x | y;
            SHR:  r[31:0] = (y >= 32) ? 32'h0 : (x >> y);
            SHRA: begin
                if (y >= 32) r[31:0] = {32{x[31]}};
                else begin
                    q = sx >>> y;
                    r[31:0] = q[31:0];
                end
            end
            SHL:  r[31:0] = (y >= 32) ? 32'h0 : (x << y);
            ROR:  r[31:0] = (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            ROL:  r[31:0] = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            MUL: begin
                r   = sx * sy;
                lat = W + 1;
            end
            DIV: begin
`ifdef MULTICYCLE_ALU_DIV_EN
                if (y == 0) begin
                    r  = {x, 32'hFFFFFFFF};
                    dz = 1'b1;
                end else begin
                    q   = sx / sy;
                    rm  = sx % sy;
                    r   = {rm[31:0], q[31:0]};
                    lat = W + 2;
                end
`else
                ill = 1'b1;
`endif
            end
            NEG:  r[31:0] = -x;
            NOT_: r[31:0] = ~x;
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one operation, scramble the pins after acceptance, poke start while busy,
    // then check latency, result, flags and the one-cycle done pulse.
    task automatic runOp(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        logic [2*W-1:0] expR;
        logic           expDz, expIll;
        int             expLat, cycles, busyLow;
        refModel(o, x, y, expR, expDz, expIll, expLat);
        @(negedge clock);
        opIn = o; aIn = x; bIn = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        opIn = 5'($urandom); aIn = $urandom; bIn = $urandom;
        cycles = 1;
        busyLow = 0;
        while (!done && cycles < 100) begin
            if (!busy) busyLow++;
            start = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            cycles++;
        end
        start = 1'b0;
        checkVal({tag, "/done"}, done, 1);
        checkVal({tag, "/latency"}, cycles, expLat);
        checkVal({tag, "/result"}, result, expR);
        checkVal({tag, "/div_zero"}, divZero, expDz);
        checkVal({tag, "/illegal_op"}, illegalOp, expIll);
        checkVal({tag, "/busy_at_done"}, busy, 0);
        checkVal({tag, "/busy_low_cycles"}, busyLow, 0);
        @(posedge clock); #1;
        checkVal({tag, "/done_pulse"}, done, 0);
        checkVal({tag, "/result_hold"}, result, expR);
    endtask

    initial begin
        int doneSeen;
        logic [4:0] o;
        logic [W-1:0] x, y;

        clear = 1'b1; start = 1'b0; opIn = '0; aIn = '0; bIn = '0;
        repeat (3) @(posedge clock);
        #1;
        checkVal("reset/busy", busy, 0);
        checkVal("reset/done", done, 0);
        checkVal("reset/result", result, 0);
        checkVal("reset/div_zero", divZero, 0);
        checkVal("reset/illegal_op", illegalOp, 0);
        @(negedge clock);
        clear = 1'b0;

        // Back-to-back single-cycle ops: done high on two consecutive cycles.
        @(negedge clock);
        opIn = ADD; aIn = 32'hFFFFFFFF; bIn = 32'd1; start = 1'b1;
        @(posedge clock); #1;
        checkVal("b2b/add_done", done, 1);
        checkVal("b2b/add_result", result, 0);
        opIn = SUB; aIn = 32'd0; bIn = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        checkVal("b2b/sub_done", done, 1);
        checkVal("b2b/sub_result", result, 64'h00000000_FFFFFFFF);
        @(posedge clock); #1;
        checkVal("b2b/idle_done", done, 0);

        runOp("mul", MUL, 32'hFFFFFFFD, 32'd7);
        checkVal("mul/plan_value", result, 64'hFFFFFFFF_FFFFFFEB);

        runOp("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE);
`ifdef MULTICYCLE_ALU_DIV_EN
        checkVal("div_7_m2/plan_value", result, 64'h00000001_FFFFFFFD);
`else
        checkVal("div_7_m2/plan_value", result, 0);
`endif
        runOp("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2);
        runOp("div_by_zero", DIV, 32'd5, 32'd0);
        runOp("add_after_dz", ADD, 32'd10, 32'd20);
        runOp("ror_33", ROR, 32'h80000001, 32'd33);
        checkVal("ror_33/plan_value", result, 64'h00000000_C0000000);
        runOp("rol_0", ROL, 32'h12345678, 32'd0);
        runOp("shra_40", SHRA, 32'h80000000, 32'd40);
        runOp("shl_32", SHL, 32'hFFFFFFFF, 32'd32);
        runOp("neg_min", NEG, 32'h80000000, 32'd0);
        runOp("mul_min_min", MUL, 32'h80000000, 32'h80000000);
        runOp("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF);
        runOp("illegal", 5'd0, 32'd1, 32'd2);

        // clear drops the illegal_op flag.
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        checkVal("clear/illegal_op", illegalOp, 0);
        @(negedge clock);
        clear = 1'b0;

        // clear 10 cycles into a multiply: discarded, no done, start ignored.
        runOp("pre_clear_add", ADD, 32'h12, 32'h34);
        @(negedge clock);
        opIn = MUL; aIn = 32'd123; bIn = 32'd456; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear = 1'b1; start = 1'b1; opIn = ADD; aIn = 32'd1; bIn = 32'd1;
        @(posedge clock); #1;
        checkVal("midclear/busy", busy, 0);
        checkVal("midclear/done", done, 0);
        checkVal("midclear/result", result, 0);
        checkVal("midclear/div_zero", divZero, 0);
        clear = 1'b0; start = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) doneSeen++;
        end
        checkVal("midclear/no_done", doneSeen, 0);
        runOp("mul_after_clear", MUL, 32'hFFFF0001, 32'h00012345);

        // Randomized operations, biased toward boundary operands.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 2) o = 5'($urandom_range(0, 31));
            else o = LISTED[$urandom_range(0, 12)];
            case ($urandom_range(0, 5))
                0: x = 32'h80000000;
                1: x = 32'h7FFFFFFF;
                2: x = 32'hFFFFFFFF;
                3: x = 32'h0;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'($urandom_range(0, 40));
                1: y = 32'h0;
                2: y = 32'hFFFFFFFF;
                3: y = 32'h80000000;
                default: y = $urandom;
            endcase
            runOp("random", o, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
